// File: rtl/depacketizer_vc_rx.sv
// NoC egress depacketizer: validates head/body/tail flits of one VC packet,
// strips the headers and presents the reassembled payload on a valid/ready port.
module depacketizer_vc_rx #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int FLIT_WIDTH       = 36,
    parameter int MAX_FLITS        = 4,
    parameter int WIDTH_OUT        = 124
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FLIT_WIDTH-1:0]            flit_in,
    input  logic                             flit_valid_in,
    output logic                             flit_ready_out,
    output logic [WIDTH_OUT-1:0]             data_out,
    output logic [ADDRESS_WIDTH-1:0]         dst_out,
    output logic [VC_ADDRESS_WIDTH-1:0]      vc_out,
    output logic [$clog2(MAX_FLITS+1)-1:0]   flits_out,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic                             err_out
);

    localparam int H   = 3 + VC_ADDRESS_WIDTH;
    localparam int P   = FLIT_WIDTH - H;
    localparam int CAP = MAX_FLITS * P - ADDRESS_WIDTH;
    localparam int DW  = P - ADDRESS_WIDTH;
    localparam int FCW = $clog2(MAX_FLITS + 1);

    // Handshakes: a flit moves when flit_valid_in && flit_ready_out at a rising
    // edge; the output word moves when valid_out && ready_in at a rising edge.
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, OUTPUT} state_t;

    state_t                      state, state_n;
    logic [CAP-1:0]              buffer, buffer_n;
    logic [ADDRESS_WIDTH-1:0]    dst_n;
    logic [VC_ADDRESS_WIDTH-1:0] vc_n;
    logic [FCW-1:0]              flits_n;
    logic                        err_n;
    logic                        do_head, do_append;

    logic                        f_valid, f_head, f_tail, accept;
    logic [VC_ADDRESS_WIDTH-1:0] f_vc;
    logic [P-1:0]                f_payload;

    assign f_valid   = flit_in[FLIT_WIDTH-1];
    assign f_head    = flit_in[FLIT_WIDTH-2];
    assign f_tail    = flit_in[FLIT_WIDTH-3];
    assign f_vc      = flit_in[P +: VC_ADDRESS_WIDTH];
    assign f_payload = flit_in[P-1:0];
    assign accept    = flit_valid_in && flit_ready_out && f_valid;

    assign data_out = buffer[CAP-1 -: WIDTH_OUT];

    always_comb begin
        state_n   = state;
        buffer_n  = buffer;
        dst_n     = dst_out;
        vc_n      = vc_out;
        flits_n   = flits_out;
        err_n     = 1'b0;
        do_head   = 1'b0;
        do_append = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (f_head) do_head = 1'b1;
                    else        err_n   = 1'b1;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (f_head) begin
                        err_n   = 1'b1;
                        do_head = 1'b1;
                    end else if (f_vc != vc_out) begin
                        err_n   = 1'b1;
                        state_n = f_tail ? IDLE : DRAIN;
                    end else if (f_tail) begin
                        do_append = 1'b1;
                        state_n   = OUTPUT;
                    end else if (flits_out == FCW'(MAX_FLITS - 1)) begin
                        // a body here would leave no slot for the tail
                        err_n   = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        do_append = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (f_head)      do_head = 1'b1;
                    else if (f_tail) state_n = IDLE;
                end
            end
            OUTPUT: begin
                if (ready_in) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (do_head) begin
            buffer_n              = '0;
            buffer_n[CAP-1 -: DW] = f_payload[DW-1:0];
            dst_n                 = f_payload[P-1 -: ADDRESS_WIDTH];
            vc_n                  = f_vc;
            flits_n               = FCW'(1);
            state_n               = f_tail ? OUTPUT : COLLECT;
        end

        // body k lands directly below the head segment, k-1 slots further down
        if (do_append) begin
            for (int k = 1; k < MAX_FLITS; k++) begin
                if (flits_out == FCW'(k))
                    buffer_n[CAP-1-DW-(k-1)*P -: P] = f_payload;
            end
            flits_n = flits_out + FCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            buffer         <= '0;
            dst_out        <= '0;
            vc_out         <= '0;
            flits_out      <= '0;
            err_out        <= 1'b0;
            valid_out      <= 1'b0;
            flit_ready_out <= 1'b1;
        end else begin
            state          <= state_n;
            buffer         <= buffer_n;
            dst_out        <= dst_n;
            vc_out         <= vc_n;
            flits_out      <= flits_n;
            err_out        <= err_n;
            valid_out      <= (state_n == OUTPUT);
            flit_ready_out <= (state_n != OUTPUT);
        end
    end

endmodule

// File: tb/tb_depacketizer_vc_rx.sv
// Bench for depacketizer_vc_rx: packet-level stimulus, expected words queued on
// issue and popped by an independent output monitor.
module tb_depacketizer_vc_rx;

    logic         clk;
    logic         rst;
    logic [35:0]  flit_in;
    logic         flit_valid_in;
    logic         flit_ready_out;
    logic [123:0] data_out;
    logic [3:0]   dst_out;
    logic [0:0]   vc_out;
    logic [2:0]   flits_out;
    logic         valid_out;
    logic         ready_in;
    logic         err_out;

    depacketizer_vc_rx dut (
        .clk            (clk),
        .rst            (rst),
        .flit_in        (flit_in),
        .flit_valid_in  (flit_valid_in),
        .flit_ready_out (flit_ready_out),
        .data_out       (data_out),
        .dst_out        (dst_out),
        .vc_out         (vc_out),
        .flits_out      (flits_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .err_out        (err_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int checks    = 0;
    int passes    = 0;
    int err_cnt   = 0;
    int exp_err   = 0;
    bit rand_ready = 1'b0;
    bit rand_mode  = 1'b0;
    logic [131:0] exp_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got %0h with nothing expected",
                         {data_out, dst_out, vc_out, flits_out});
            end else begin
                check("output", {data_out, dst_out, vc_out, flits_out}, exp_q[0]);
                if (ready_in) void'(exp_q.pop_front());
            end
        end
        if (!rst && err_out) err_cnt++;
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rand_ready) begin
                #1;
                ready_in = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // reference model: packet-level expectation
    function automatic logic [131:0] pkt_exp(input logic [3:0] dst, input logic vc,
                                             input logic [27:0] hd, input int nb,
                                             input logic [31:0] b0, b1, b2);
        logic [123:0] d;
        logic [31:0]  b[3];
        b[0] = b0;
        b[1] = b1;
        b[2] = b2;
        d = {hd, 96'b0};
        for (int j = 1; j <= nb; j++)
            d = d | (124'(b[j-1]) << (96 - 32 * j));
        return {d, dst, vc, 3'(nb + 1)};
    endfunction

    function automatic logic [35:0] mk(input logic h, input logic t, input logic vc,
                                       input logic [31:0] pl);
        return {1'b1, h, t, vc, pl};
    endfunction

    // driver tasks; all start and end one time unit after a rising edge
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [35:0] f);
        int waited;
        waited = 0;
        flit_in       = f;
        flit_valid_in = 1'b1;
        @(negedge clk);
        while (!flit_ready_out && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!flit_ready_out) begin
            checks++;
            $display("FAIL send_timeout: flit %0h not accepted, ready %0b required 1", f, flit_ready_out);
        end
        @(posedge clk);
        #1;
        flit_valid_in = 1'b0;
    endtask

    task automatic gap();
        int n;
        n = rand_mode ? $urandom_range(0, 2) : 0;
        repeat (n) begin
            flit_valid_in = 1'($urandom);
            flit_in       = {1'b0, 3'($urandom), 32'($urandom)};
            sync();
        end
        flit_valid_in = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] dst, input logic vc, input logic [27:0] hd,
                            input int nb, input logic [31:0] b0, b1, b2);
        logic [31:0] b[3];
        b[0] = b0;
        b[1] = b1;
        b[2] = b2;
        exp_q.push_back(pkt_exp(dst, vc, hd, nb, b0, b1, b2));
        send_flit(mk(1'b1, nb == 0, vc, {dst, hd}));
        for (int j = 1; j <= nb; j++) begin
            gap();
            send_flit(mk(1'b0, j == nb, vc, b[j-1]));
        end
    endtask

    task automatic check_err();
        repeat (3) @(negedge clk);
        check("err_count", err_cnt, exp_err);
        sync();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        sync();
    endtask

    initial begin
        logic vc_a;
        int   nb;
        rst           = 1'b1;
        flit_in       = '0;
        flit_valid_in = 1'b0;
        ready_in      = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_valid", valid_out, 0);
        check("reset_data", data_out, 0);
        check("reset_err", err_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", flit_ready_out, 1);
        check("reset_flits", flits_out, 0);
        sync();

        // single head+tail flit, latency of one cycle
        send_pkt(4'h5, 1'b1, 28'hABCDEF1, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("latency_valid", valid_out, 1);
        sync();
        ready_in = 1'b1;
        wait_drain();

        // four flits with a five-cycle stall downstream
        ready_in = 1'b0;
        send_pkt(4'h3, 1'b0, 28'h1111111, 3, 32'h22222222, 32'h33333333, 32'h44444444);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_ready_low", flit_ready_out, 0);
            check("hold_valid", valid_out, 1);
        end
        sync();
        ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_after_handshake", valid_out, 0);
        check("ready_after_handshake", flit_ready_out, 1);
        sync();

        // body flit while idle
        send_flit(mk(1'b0, 1'b0, 1'b0, $urandom));
        exp_err++;
        check_err();
        send_pkt(4'hC, 1'b0, 28'h0FEDCBA, 0, 32'h0, 32'h0, 32'h0);
        wait_drain();

        // vc change mid-packet, remaining flits drained
        send_flit(mk(1'b1, 1'b0, 1'b0, {4'h2, 28'h5555555}));
        send_flit(mk(1'b0, 1'b0, 1'b1, 32'h66666666));
        exp_err++;
        send_flit(mk(1'b0, 1'b0, 1'b0, 32'h77777777));
        send_flit(mk(1'b0, 1'b1, 1'b1, 32'h88888888));
        check_err();
        send_pkt(4'h7, 1'b1, 28'h9ABCDEF, 2, 32'h01234567, 32'h89ABCDEF, 32'h0);
        wait_drain();

        // too many flits without a tail, then a head while draining
        send_flit(mk(1'b1, 1'b0, 1'b0, {4'h1, 28'h1212121}));
        send_flit(mk(1'b0, 1'b0, 1'b0, 32'h34343434));
        send_flit(mk(1'b0, 1'b0, 1'b0, 32'h56565656));
        send_flit(mk(1'b0, 1'b0, 1'b0, 32'h78787878));
        exp_err++;
        check_err();
        send_pkt(4'hE, 1'b0, 28'hAAAAAAA, 1, 32'hBBBBBBBB, 32'h0, 32'h0);
        wait_drain();
        check_err();

        // head arriving mid-packet restarts capture
        send_flit(mk(1'b1, 1'b0, 1'b1, {4'h4, 28'h4444444}));
        exp_err++;
        send_pkt(4'h6, 1'b0, 28'h6060606, 1, 32'h60606060, 32'h0, 32'h0);
        wait_drain();
        check_err();

        // asynchronous reset in the middle of a packet
        send_flit(mk(1'b1, 1'b0, 1'b1, {4'h9, 28'h1234567}));
        send_flit(mk(1'b0, 1'b0, 1'b1, 32'hDEADBEEF));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", valid_out, 0);
        check("async_rst_data", data_out, 0);
        check("async_rst_dst", dst_out, 0);
        check("async_rst_vc", vc_out, 0);
        check("async_rst_flits", flits_out, 0);
        check("async_rst_err", err_out, 0);
        check("async_rst_ready", flit_ready_out, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sync();
        send_pkt(4'hA, 1'b1, 28'h7654321, 1, 32'hCAFEF00D, 32'h0, 32'h0);
        wait_drain();
        check_err();

        // randomized packets and error cases
        rand_mode  = 1'b1;
        rand_ready = 1'b1;
        for (int it = 0; it < 200; it++) begin
            vc_a = 1'($urandom);
            case ($urandom_range(0, 5))
                0, 1: begin
                    nb = $urandom_range(0, 3);
                    send_pkt(4'($urandom), vc_a, 28'($urandom), nb, $urandom, $urandom, $urandom);
                end
                2: begin
                    send_flit(mk(1'b0, 1'($urandom), vc_a, $urandom));
                    exp_err++;
                    check_err();
                end
                3: begin
                    send_flit(mk(1'b1, 1'b0, vc_a, $urandom));
                    repeat ($urandom_range(0, 1)) send_flit(mk(1'b0, 1'b0, vc_a, $urandom));
                    if ($urandom_range(0, 1) == 1) begin
                        send_flit(mk(1'b0, 1'b1, ~vc_a, $urandom));
                    end else begin
                        send_flit(mk(1'b0, 1'b0, ~vc_a, $urandom));
                        repeat ($urandom_range(0, 2)) send_flit(mk(1'b0, 1'b0, 1'($urandom), $urandom));
                        send_flit(mk(1'b0, 1'b1, 1'($urandom), $urandom));
                    end
                    exp_err++;
                    check_err();
                end
                4: begin
                    send_flit(mk(1'b1, 1'b0, vc_a, $urandom));
                    repeat (3) begin
                        gap();
                        send_flit(mk(1'b0, 1'b0, vc_a, $urandom));
                    end
                    exp_err++;
                    if ($urandom_range(0, 1) == 1)
                        send_flit(mk(1'b0, 1'b1, vc_a, $urandom));
                    else
                        send_pkt(4'($urandom), 1'($urandom), 28'($urandom), $urandom_range(0, 3),
                                 $urandom, $urandom, $urandom);
                    check_err();
                end
                default: begin
                    send_flit(mk(1'b1, 1'b0, vc_a, $urandom));
                    repeat ($urandom_range(0, 1)) send_flit(mk(1'b0, 1'b0, vc_a, $urandom));
                    exp_err++;
                    send_pkt(4'($urandom), 1'($urandom), 28'($urandom), $urandom_range(0, 3),
                             $urandom, $urandom, $urandom);
                    check_err();
                end
            endcase
            gap();
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        ready_in = 1'b1;
        wait_drain();
        check_err();

        // final report
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
